ptw_arb: RTL and testbench
==========================

PTW_ARB -- requirements
Module: ptw_arb

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning round-robin arbitration when 1 and fixed I-port priority when 0.
REQ-002 The block SHALL have port ptw_clk_i, input, 1, clock.
REQ-003 The block SHALL have port ptw_arst_i, input, 1, reset, asynchronous, active-high.
REQ-004 The block SHALL have port flush_i, input, 1, sfence.vma/satp-write kill of the outstanding walk.
REQ-005 The block SHALL have ports itlb_req_valid_i / dtlb_req_valid_i, input, 1 each, walk request.
REQ-006 The block SHALL have ports itlb_req_vpn_i / dtlb_req_vpn_i, input, 27 each, Sv39 VPN.
REQ-007 The block SHALL have ports itlb_req_ready_o / dtlb_req_ready_o, output, 1 each, request accepted this cycle.
REQ-008 The block SHALL have ports itlb_rsp_valid_o / dtlb_rsp_valid_o, output, 1 each, one-cycle response pulse.
REQ-009 The block SHALL have ports rsp_ppn_o (44), rsp_pte_o (10), rsp_pgsize_o (2) and rsp_error_o (1), all outputs, shared response payload.
REQ-010 The block SHALL have ports ptw_valid_o (output, 1) and ptw_vpn_o (output, 27), the walker command.
REQ-011 The block SHALL have ports ptw_ready_i (input, 1), ptw_ppn_i (input, 44), ptw_pte_i (input, 10), ptw_pgsize_i (input, 2) and ptw_error_i (input, 1), the walker result.

Function
REQ-012 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-013 In IDLE with any req_valid and no flush_i, the block SHALL grant one port, pulse that port's req_ready_o in the same cycle, latch port id and VPN, and go to ISSUE.
REQ-014 Arbitration: when both ports are valid, the grant SHALL go to the port not served last (rr bit); with a single requester that requester SHALL be granted; with RR_EN=0 the I port SHALL always win.
REQ-015 ISSUE SHALL drive ptw_valid_o=1 with ptw_vpn_o equal to the latched VPN for exactly one cycle, then go to WAIT; ptw_valid_o SHALL be 0 in all other states.
REQ-016 In WAIT, on ptw_ready_i the block SHALL register ppn/pte/pgsize/error and go to RESP; it SHALL ignore ptw_ready_i in every other state.
REQ-017 RESP SHALL pulse the owner's rsp_valid_o for one cycle with the registered payload, update rr, and return to IDLE; responses are not back-pressured.
REQ-018 Latency: accept at cycle 0, ptw_valid_o at cycle 1, and rsp_valid_o one cycle after ptw_ready_i.
REQ-019 At most one walk SHALL be outstanding; req_ready_o SHALL be 0 outside IDLE.
REQ-020 Flush: flush_i in ISSUE or WAIT SHALL set the kill flag; the walk still completes, ptw_ready_i then returns the FSM to IDLE with no rsp_valid_o, and kill is cleared.
REQ-021 Flush in RESP SHALL suppress rsp_valid_o for that cycle; flush in IDLE SHALL block the grant that cycle.
REQ-022 A flush coincident with ptw_ready_i SHALL discard that result.
REQ-023 rsp_error_o SHALL pass through ptw_error_i unmodified; on error, ppn/pte are don't-care for the consumer.
REQ-024 rsp_* payload SHALL hold its value outside RESP; the value is don't-care for consumers.

Reset
REQ-025 On ptw_arst_i the block SHALL set state=IDLE, kill=0, rr=D-last (I-port favoured first), and all valid/ready outputs to 0.
REQ-026 Payload and VPN registers SHALL be reset to 0.
REQ-027 Reset asserted mid-walk SHALL abandon the walk; the walker is reset by the same signal.

Structure
REQ-028 Shared package ptw_pkg SHALL hold the state enum, the port-id enum (PORT_I, PORT_D), and the ptw_rsp_t struct {ppn[43:0], pte[9:0], pgsize[1:0], error}.
REQ-029 The arbiter SHALL be sub-module ptw_rr_arb2 (2-way round-robin, grant one-hot, advance input).

Verification
REQ-030 Reset only I request vpn=27'h1ABCDE -> itlb_req_ready_o at cycle 0, ptw_valid_o one cycle with ptw_vpn_o=27'h1ABCDE; ptw_ready_i with ppn=44'h12345 -> itlb_rsp_valid_o next cycle, ppn 44'h12345, dtlb_rsp_valid_o=0.
REQ-031 I and D both held valid from reset -> grants in order I, D, I, D over four walks; with RR_EN=0 -> I, I, I, I.
REQ-032 D walk returns ptw_error_i=1, pgsize=2 -> dtlb_rsp_valid_o=1, rsp_error_o=1, rsp_pgsize_o=2.
REQ-033 flush_i pulse in WAIT -> no rsp_valid_o on completion; the next request is granted from IDLE afterwards.
REQ-034 ptw_arst_i asserted in WAIT -> all outputs 0 next edge and state=IDLE; a stale ptw_ready_i after reset produces no response.
REQ-035 Both req_valid held while a walk is outstanding -> req_ready_o stays 0 and ptw_valid_o is never asserted twice per walk.

Source files
------------

// File: rtl/ptw_pkg.sv
// Shared types for the page-table-walk request arbiter.
// States, port ids and the walker response bundle.
package ptw_pkg;

  localparam int VPN_W = 27;
  localparam int PPN_W = 44;
  localparam int PTE_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } ptw_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } ptw_port_e;

  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    logic [PTE_W-1:0] pte;
    logic [1:0]       pgsize;
    logic             error;
  } ptw_rsp_t;

endpackage

// File: rtl/ptw_rr_arb2.sv
// Two-way arbiter, one-hot grant (bit 0 = I, bit 1 = D).
// Remembers the last served port and favours the other.
module ptw_rr_arb2
  import ptw_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       ptw_clk_i,
  input  logic       ptw_arst_i,
  input  logic [1:0] req,
  input  logic       advance,
  input  ptw_port_e  served,
  output logic [1:0] gnt
);

  ptw_port_e last_q;

  always_ff @(posedge ptw_clk_i or posedge ptw_arst_i) begin
    if (ptw_arst_i) begin
      last_q <= PORT_D;
    end else if (advance) begin
      last_q <= served;
    end
  end

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11):
        gnt = (RR_EN && last_q == PORT_I) ? 2'b10 : 2'b01;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ptw_arb.sv
// Arbitrates I/D TLB misses onto one page-table walker.
// One walk in flight; flushed walks complete silently.
module ptw_arb
  import ptw_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic             ptw_clk_i,
  input  logic             ptw_arst_i,
  input  logic             flush_i,
  input  logic             itlb_req_valid_i,
  input  logic             dtlb_req_valid_i,
  input  logic [VPN_W-1:0] itlb_req_vpn_i,
  input  logic [VPN_W-1:0] dtlb_req_vpn_i,
  output logic             itlb_req_ready_o,
  output logic             dtlb_req_ready_o,
  output logic             itlb_rsp_valid_o,
  output logic             dtlb_rsp_valid_o,
  output logic [PPN_W-1:0] rsp_ppn_o,
  output logic [PTE_W-1:0] rsp_pte_o,
  output logic [1:0]       rsp_pgsize_o,
  output logic             rsp_error_o,
  output logic             ptw_valid_o,
  output logic [VPN_W-1:0] ptw_vpn_o,
  input  logic             ptw_ready_i,
  input  logic [PPN_W-1:0] ptw_ppn_i,
  input  logic [PTE_W-1:0] ptw_pte_i,
  input  logic [1:0]       ptw_pgsize_i,
  input  logic             ptw_error_i
);

  ptw_state_e       state_q, state_d;
  ptw_port_e        owner_q;
  logic [VPN_W-1:0] vpn_q;
  logic             kill_q, kill_d;
  ptw_rsp_t         rsp_q;
  logic [1:0]       req, gnt;
  logic             acc, cap, adv;

  assign req = {dtlb_req_valid_i, itlb_req_valid_i}
             & {2{state_q == ST_IDLE && !flush_i}};

  ptw_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .ptw_clk_i (ptw_clk_i),
    .ptw_arst_i(ptw_arst_i),
    .req       (req),
    .advance   (adv),
    .served    (owner_q),
    .gnt       (gnt)
  );

  assign itlb_req_ready_o = gnt[0];
  assign dtlb_req_ready_o = gnt[1];
  assign ptw_vpn_o        = vpn_q;
  assign rsp_ppn_o        = rsp_q.ppn;
  assign rsp_pte_o        = rsp_q.pte;
  assign rsp_pgsize_o     = rsp_q.pgsize;
  assign rsp_error_o      = rsp_q.error;

  always_comb begin
    state_d          = state_q;
    kill_d           = kill_q;
    acc              = 1'b0;
    cap              = 1'b0;
    adv              = 1'b0;
    ptw_valid_o      = 1'b0;
    itlb_rsp_valid_o = 1'b0;
    dtlb_rsp_valid_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          acc     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ptw_valid_o = 1'b1;
        state_d     = ST_WAIT;
        if (flush_i) kill_d = 1'b1;
      end
      ST_WAIT: begin
        if (ptw_ready_i) begin
          // a flush on the completing cycle also discards the result
          cap     = !(kill_q || flush_i);
          state_d = cap ? ST_RESP : ST_IDLE;
          kill_d  = 1'b0;
        end else if (flush_i) begin
          kill_d = 1'b1;
        end
      end
      ST_RESP: begin
        adv              = 1'b1;
        state_d          = ST_IDLE;
        itlb_rsp_valid_o = !flush_i && owner_q == PORT_I;
        dtlb_rsp_valid_o = !flush_i && owner_q == PORT_D;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ptw_clk_i or posedge ptw_arst_i) begin
    if (ptw_arst_i) begin
      state_q <= ST_IDLE;
      kill_q  <= 1'b0;
      owner_q <= PORT_I;
      vpn_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (acc) begin
        owner_q <= gnt[1] ? PORT_D : PORT_I;
        vpn_q   <= gnt[1] ? dtlb_req_vpn_i : itlb_req_vpn_i;
      end
      if (cap) begin
        rsp_q <= '{ppn: ptw_ppn_i, pte: ptw_pte_i,
                   pgsize: ptw_pgsize_i, error: ptw_error_i};
      end
    end
  end

endmodule

// File: tb/tb_ptw_arb.sv
// Bench for ptw_arb: directed walks plus random traffic
// checked every cycle against a transaction-level model.
module tb_ptw_arb;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        flush = 1'b0;
  logic        iv = 1'b0, dv = 1'b0;
  logic [26:0] ivpn = '0, dvpn = '0;
  logic        pready = 1'b0;
  logic [43:0] pppn = '0;
  logic [9:0]  ppte = '0;
  logic [1:0]  ppg = '0;
  logic        perr = 1'b0;

  logic        irdy, drdy, irsp, drsp, rerr, pvalid;
  logic [43:0] rppn;
  logic [9:0]  rpte;
  logic [1:0]  rpg;
  logic [26:0] pvpn;

  logic        irdy0, drdy0, irsp0, drsp0, rerr0, pvalid0;
  logic [43:0] rppn0;
  logic [9:0]  rpte0;
  logic [1:0]  rpg0;
  logic [26:0] pvpn0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ptw_arb #(.RR_EN(1'b1)) dut (
    .ptw_clk_i(clk), .ptw_arst_i(arst), .flush_i(flush),
    .itlb_req_valid_i(iv), .dtlb_req_valid_i(dv),
    .itlb_req_vpn_i(ivpn), .dtlb_req_vpn_i(dvpn),
    .itlb_req_ready_o(irdy), .dtlb_req_ready_o(drdy),
    .itlb_rsp_valid_o(irsp), .dtlb_rsp_valid_o(drsp),
    .rsp_ppn_o(rppn), .rsp_pte_o(rpte),
    .rsp_pgsize_o(rpg), .rsp_error_o(rerr),
    .ptw_valid_o(pvalid), .ptw_vpn_o(pvpn),
    .ptw_ready_i(pready), .ptw_ppn_i(pppn), .ptw_pte_i(ppte),
    .ptw_pgsize_i(ppg), .ptw_error_i(perr)
  );

  ptw_arb #(.RR_EN(1'b0)) dut0 (
    .ptw_clk_i(clk), .ptw_arst_i(arst), .flush_i(flush),
    .itlb_req_valid_i(iv), .dtlb_req_valid_i(dv),
    .itlb_req_vpn_i(ivpn), .dtlb_req_vpn_i(dvpn),
    .itlb_req_ready_o(irdy0), .dtlb_req_ready_o(drdy0),
    .itlb_rsp_valid_o(irsp0), .dtlb_rsp_valid_o(drsp0),
    .rsp_ppn_o(rppn0), .rsp_pte_o(rpte0),
    .rsp_pgsize_o(rpg0), .rsp_error_o(rerr0),
    .ptw_valid_o(pvalid0), .ptw_vpn_o(pvpn0),
    .ptw_ready_i(pready), .ptw_ppn_i(pppn), .ptw_pte_i(ppte),
    .ptw_pgsize_i(ppg), .ptw_error_i(perr)
  );

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: one walk record (port, vpn, phase) and the last served port.
  bit          m_busy = 0;
  bit          m_owner = 0;
  bit          m_last = 1;
  bit          m_kill = 0;
  bit          m_res_ok = 0;
  int          m_age = 0;
  logic [26:0] m_vpn = '0;
  logic [43:0] m_ppn = '0;
  logic [9:0]  m_pte = '0;
  logic [1:0]  m_pg = '0;
  logic        m_err = 1'b0;

  bit rec_en = 0;
  int gq[$];
  int gq0[$];

  always @(negedge clk) begin
    bit grant, pick, e_pv, e_rsp;
    if (arst) begin
      check("rst_irdy", 64'(irdy), 0);
      check("rst_drdy", 64'(drdy), 0);
      check("rst_pvalid", 64'(pvalid), 0);
      check("rst_irsp", 64'(irsp), 0);
      check("rst_drsp", 64'(drsp), 0);
      m_busy = 0;
      m_kill = 0;
      m_last = 1;
    end else begin
      grant = !m_busy && !flush && (iv || dv);
      pick  = (iv && dv) ? !m_last : dv;
      e_pv  = m_busy && m_age == 1;
      e_rsp = m_busy && m_res_ok && !flush;
      check("m_irdy", 64'(irdy), 64'(grant && !pick));
      check("m_drdy", 64'(drdy), 64'(grant && pick));
      check("m_pvalid", 64'(pvalid), 64'(e_pv));
      if (e_pv) check("m_pvpn", 64'(pvpn), 64'(m_vpn));
      check("m_irsp", 64'(irsp), 64'(e_rsp && !m_owner));
      check("m_drsp", 64'(drsp), 64'(e_rsp && m_owner));
      if (e_rsp) begin
        check("m_ppn", 64'(rppn), 64'(m_ppn));
        check("m_pte", 64'(rpte), 64'(m_pte));
        check("m_pgsize", 64'(rpg), 64'(m_pg));
        check("m_error", 64'(rerr), 64'(m_err));
      end
      if (rec_en) begin
        if (irdy) gq.push_back(0);
        if (drdy) gq.push_back(1);
        if (irdy0) gq0.push_back(0);
        if (drdy0) gq0.push_back(1);
      end
      if (grant) begin
        m_busy   = 1;
        m_owner  = pick;
        m_vpn    = pick ? dvpn : ivpn;
        m_age    = 1;
        m_res_ok = 0;
        m_kill   = 0;
      end else if (m_busy) begin
        if (m_res_ok) begin
          m_busy = 0;
          m_last = m_owner;
        end else if (m_age == 1) begin
          m_age = 2;
          if (flush) m_kill = 1;
        end else if (pready) begin
          if (m_kill || flush) begin
            m_busy = 0;
          end else begin
            m_res_ok = 1;
            m_ppn = pppn;
            m_pte = ppte;
            m_pg  = ppg;
            m_err = perr;
          end
        end else if (flush) begin
          m_kill = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    iv = 1'b0;
    dv = 1'b0;
    flush = 1'b0;
    pready = 1'b0;
    tick();
    tick();
    arst = 1'b0;
  endtask

  initial begin
    do_reset();

    // lone I walk, latency and payload
    iv = 1'b1;
    ivpn = 27'h1ABCDE;
    #1 check("acc_irdy", 64'(irdy), 1);
    tick();
    iv = 1'b0;
    #1 check("iss_pvalid", 64'(pvalid), 1);
    check("iss_pvpn", 64'(pvpn), 64'h1ABCDE);
    tick();
    #1 check("wait_pvalid", 64'(pvalid), 0);
    pready = 1'b1;
    pppn = 44'h12345;
    ppte = 10'h0CF;
    ppg = 2'd0;
    perr = 1'b0;
    tick();
    pready = 1'b0;
    #1 check("rsp_irsp", 64'(irsp), 1);
    check("rsp_ppn", 64'(rppn), 64'h12345);
    check("rsp_drsp", 64'(drsp), 0);
    tick();

    // grant order with both ports held
    do_reset();
    gq.delete();
    gq0.delete();
    rec_en = 1;
    iv = 1'b1;
    dv = 1'b1;
    ivpn = 27'h11;
    dvpn = 27'h22;
    pready = 1'b1;
    repeat (16) tick();
    iv = 1'b0;
    dv = 1'b0;
    pready = 1'b0;
    rec_en = 0;
    check("rr_count", 64'(gq.size()), 4);
    check("fix_count", 64'(gq0.size()), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_grant%0d", k),
            64'(k < gq.size() ? gq[k] : 2), 64'(k % 2));
      check($sformatf("fix_grant%0d", k),
            64'(k < gq0.size() ? gq0[k] : 2), 0);
    end
    tick();

    // D walk returning an error
    do_reset();
    dv = 1'b1;
    dvpn = 27'h0F00D;
    tick();
    dv = 1'b0;
    tick();
    pready = 1'b1;
    perr = 1'b1;
    ppg = 2'd2;
    pppn = 44'hABCDE;
    tick();
    pready = 1'b0;
    perr = 1'b0;
    #1 check("err_drsp", 64'(drsp), 1);
    check("err_error", 64'(rerr), 1);
    check("err_pgsize", 64'(rpg), 2);
    check("err_irsp", 64'(irsp), 0);
    tick();

    // flush during WAIT kills the response
    iv = 1'b1;
    ivpn = 27'h00BEEF;
    tick();
    iv = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pready = 1'b1;
    pppn = 44'h777;
    tick();
    pready = 1'b0;
    iv = 1'b1;
    ivpn = 27'h00CAFE;
    #1 check("kill_irsp", 64'(irsp), 0);
    check("kill_drsp", 64'(drsp), 0);
    check("kill_regrant", 64'(irdy), 1);
    tick();
    iv = 1'b0;
    tick();
    pready = 1'b1;
    pppn = 44'h888;
    tick();
    pready = 1'b0;
    #1 check("kill_next_rsp", 64'(irsp), 1);
    check("kill_next_ppn", 64'(rppn), 64'h888);
    tick();

    // reset asserted in WAIT, stale ready afterwards
    iv = 1'b1;
    tick();
    iv = 1'b0;
    tick();
    arst = 1'b1;
    #1 check("arst_pvalid", 64'(pvalid), 0);
    check("arst_irsp", 64'(irsp), 0);
    check("arst_drsp", 64'(drsp), 0);
    tick();
    arst = 1'b0;
    pready = 1'b1;
    tick();
    pready = 1'b0;
    #1 check("stale_irsp", 64'(irsp), 0);
    check("stale_drsp", 64'(drsp), 0);
    check("stale_pvalid", 64'(pvalid), 0);
    tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(399) == 0) begin
        arst = 1'b1;
        iv = 1'b0;
        dv = 1'b0;
      end else begin
        arst = 1'b0;
        iv = 1'($urandom_range(1));
        dv = 1'($urandom_range(1));
      end
      ivpn   = 27'($urandom());
      dvpn   = 27'($urandom());
      flush  = ($urandom_range(9) == 0);
      pready = ($urandom_range(2) == 0);
      pppn   = 44'({$urandom(), $urandom()});
      ppte   = 10'($urandom());
      ppg    = 2'($urandom());
      perr   = 1'($urandom_range(1));
      tick();
    end
    arst = 1'b0;
    iv = 1'b0;
    dv = 1'b0;
    flush = 1'b0;
    pready = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
